// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and the leading-zero blanking rule for the digit scanner
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam int DEFAULT_DIV = 50000;
  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = NUM_DIGITS * DIGIT_W;
  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [VAL_W-1:0] val_t;
  function automatic logic blanked(val_t d, sel_t k, logic lz);
    return lz && k != '0 && (d >> (DIGIT_W * int'(k))) == '0;
  endfunction
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: host-side load/display bundle of the digit scanner
interface seg_scan_if;
  import seg_pkg::*;
  logic en_i;
  logic load_i;
  logic lz_blank_i;
  val_t value_i;
  logic load_ack_o;
  sel_t sel_o;
  digit_t bcd_o;
  logic digit_on_o;
  logic frame_start_o;
  modport master(output en_i, load_i, lz_blank_i, value_i,
                 input load_ack_o, sel_o, bcd_o, digit_on_o, frame_start_o);
  modport slave(input en_i, load_i, lz_blank_i, value_i,
                output load_ack_o, sel_o, bcd_o, digit_on_o, frame_start_o);
endinterface

// File: rtl/seg_prescaler.sv
// seg_prescaler: dwell counter producing one tick every DIV enabled cycles
module seg_prescaler #(
  parameter int DIV = seg_pkg::DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == CW'(DIV - 1);
  assign cnt_d = tick ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed 4-digit scan with frame-aligned value commit and leading-zero blanking
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input logic clk,
  input logic rst_n,
  seg_scan_if.slave bus
);
  logic tick, wrap, commit;
  logic pend_q, pend_d, ack_q, on_q, on_d, fs_q;
  sel_t sel_q, sel_d;
  digit_t bcd_q, bcd_d;
  val_t disp_q, disp_d, shad_q, shad_d;
  seg_prescaler #(.DIV(DIV)) u_pre (.clk(clk), .rst_n(rst_n), .en(bus.en_i), .tick(tick));
  // outputs are derived from next-state so a commit shows at sel=0 in the wrap cycle
  always_comb begin
    wrap = tick && sel_q == sel_t'(NUM_DIGITS - 1);
    commit = wrap && pend_q;
    sel_d = tick ? sel_q + sel_t'(1) : sel_q;
    disp_d = commit ? shad_q : disp_q;
    shad_d = bus.load_i ? bus.value_i : shad_q;
    pend_d = bus.load_i || (pend_q && !commit);
    bcd_d = disp_d[DIGIT_W*int'(sel_d) +: DIGIT_W];
    on_d = bus.en_i && !blanked(disp_d, sel_d, bus.lz_blank_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      disp_q <= '0;
      shad_q <= '0;
      pend_q <= 1'b0;
      ack_q <= 1'b0;
      bcd_q <= '0;
      on_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      disp_q <= disp_d;
      shad_q <= shad_d;
      pend_q <= pend_d;
      ack_q <= commit;
      bcd_q <= bcd_d;
      on_q <= on_d;
      fs_q <= wrap;
    end
  end
  assign bus.sel_o = sel_q;
  assign bus.bcd_o = bcd_q;
  assign bus.digit_on_o = on_q;
  assign bus.frame_start_o = fs_q;
  assign bus.load_ack_o = ack_q;
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 50000, digit dwell time in clk cycles; SHALL be >= 2.
REQ-002 clk  input  1  single clock for the block; all logic on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  scan enable; 0 freezes the scan and blanks the output.
REQ-005 value  input  16  four hex digits to display; digit k = value[4k+3:4k].
REQ-006 load  input  1  request to display value; sampled every cycle.
REQ-007 load_ack  output  1  one-cycle pulse when a requested value is committed to the display.
REQ-008 lz_blank  input  1  leading-zero blanking enable.
REQ-009 sel  output  2  digit index for the downstream 7-seg decoder (0 = least significant).
REQ-010 bcd  output  4  nibble for the digit at sel.
REQ-011 digit_on  output  1  1 = the current digit is lit; the top level gates the anode with it.
REQ-012 frame_start  output  1  one-cycle pulse when sel wraps 3->0.

Function
REQ-013 The prescaler SHALL count 0..DIV-1 while en=1 and wrap to 0; tick SHALL be asserted when count = DIV-1 and en=1.
REQ-014 On tick, sel SHALL increment modulo 4 (3->0 wrap), so each digit is held for exactly DIV enabled cycles.
REQ-015 With en=0, the prescaler and sel SHALL hold, no tick SHALL occur, and digit_on SHALL be 0 from the next cycle.
REQ-016 load=1 SHALL write value into the shadow register and set pending; the last load before a commit wins.
REQ-017 Commit SHALL occur on the tick that wraps sel 3->0 while pending=1: display register <= shadow, pending cleared, load_ack=1 for exactly the following cycle.
REQ-018 If load=1 on a commit tick, the old shadow SHALL be committed and acknowledged, and the new value SHALL be captured with pending left at 1 for the next frame.
REQ-019 If load=1 on a wrap tick with pending=0, the value SHALL be captured only; commit SHALL follow on the next wrap.
REQ-020 Each accepted commit SHALL give exactly one load_ack; no ack SHALL be given without a pending value.
REQ-021 sel, bcd, digit_on and frame_start SHALL be registered and SHALL change in the same cycle.
REQ-022 bcd SHALL equal nibble sel of the display register.
REQ-023 This alignment means a committed value first appears at sel=0 in the cycle of the wrap.
REQ-024 digit_on SHALL be en AND NOT blanked, where digit k is blanked iff lz_blank=1, k>0, and nibbles k..3 of the display register are all zero.
REQ-025 Digit 0 SHALL never be blanked.
REQ-026 frame_start SHALL be 1 for exactly one cycle, in the cycle sel becomes 0 after a tick.

Reset
REQ-027 On rst_n=0, immediately and regardless of clk, the following SHALL be 0: prescaler, sel, display register, shadow, pending, load_ack, bcd, digit_on and frame_start.
REQ-028 Reset mid-frame SHALL discard a pending load, and no load_ack SHALL follow reset release.
REQ-029 Operation SHALL resume at sel=0 with count=0 on the first clk edge after release.

Structure
REQ-030 Shared package seg_pkg SHALL hold NUM_DIGITS=4, DIGIT_W=4 and DEFAULT_DIV=50000.
REQ-031 The prescaler SHALL be a sub-module seg_prescaler (parameter DIV; ports clk, rst_n, en, tick).
REQ-032 Scan, commit and blanking logic SHALL reside in seg_scan.

Verification (DIV=4)
REQ-033 Scan order: reset, en=1, load 16'h1234 -> after the first wrap, load_ack pulses once; sel 0,1,2,3 each held 4 cycles with bcd 4,3,2,1; frame_start every 16 cycles.
REQ-034 Load mid-frame: load 16'hABCD while sel=1 -> display unchanged until the 3->0 wrap; then bcd=D at sel=0 and a single load_ack.
REQ-035 Coalescing: load 16'h1111 then 16'h2222 in the same frame -> one load_ack; display shows 2222.
REQ-036 Load on a commit tick -> old value acked; the new value commits on the following wrap.
REQ-037 Blanking: lz_blank=1 with value 16'h0050 -> digit_on 1 at sel 0,1 and 0 at sel 2,3; value 16'h0000 -> only sel=0 lit.
REQ-038 Freeze: en=0 at count 2 of sel=2 -> sel holds 2 and digit_on=0 from the next cycle; en=1 -> sel advances after 1 more cycle.
REQ-039 Reset with a pending load at sel=3 -> all outputs 0 immediately; no load_ack after release; scan resumes at sel=0.
